// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: the requester drives start and operands,
// the adder returns busy/done and the registered result.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             Sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             Ovf;

   modport master (
      output start, A, B, Cin, Sub,
      input  busy, done, S, Cout, Ovf
   );

   modport slave (
      input  start, A, B, Cin, Sub,
      output busy, done, S, Cout, Ovf
   );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock over WIDTH/DIGIT cycles, with a
// registered carry between digits, start/busy/done handshake and signed overflow.
module serial_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus_io
);
   localparam int unsigned N    = WIDTH / DIGIT;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT:0]   chain;
   logic [DIGIT-1:0] dig_sum;
   logic [WIDTH-1:0] sum_shift;
   logic             last_digit;

   // One DIGIT-bit ripple of full-adder cells fed by the registered carry.
   always_comb begin
      chain[0] = carry_q;
      dig_sum  = '0;
      for (int i = 0; i < DIGIT; i++) begin
         dig_sum[i]   = a_q[i] ^ b_q[i] ^ chain[i];
         chain[i + 1] = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
      end
   end

   // Digit sums enter at the MSB so that after N digits the register is in bit order.
   always_comb begin
      sum_shift                    = sum_q >> DIGIT;
      sum_shift[WIDTH-1 -: DIGIT]  = dig_sum;
   end

   assign last_digit = (cnt_q == CntW'(N - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         StIdle, StDone: begin
            if (bus_io.start) begin
               state_d = StRun;
               a_d     = bus_io.A;
               // Subtract runs as A + ~B + !borrow, so B is stored inverted.
               b_d     = bus_io.Sub ? ~bus_io.B : bus_io.B;
               carry_d = bus_io.Cin ^ bus_io.Sub;
               cnt_d   = '0;
               sum_d   = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            sum_d   = sum_shift;
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = chain[DIGIT];
            cnt_d   = cnt_q + CntW'(1);
            if (last_digit) begin
               state_d = StDone;
               s_d     = sum_shift;
               cout_d  = chain[DIGIT];
               ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus_io.busy = (state_q == StRun);
   assign bus_io.done = (state_q == StDone);
   assign bus_io.S    = s_q;
   assign bus_io.Cout = cout_q;
   assign bus_io.Ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (8/1, 8/4, 4/2) sharing one stimulus
// driver; expected results are queued at acceptance and compared on each done pulse.
module tb_serial_adder;
   typedef struct packed {
      logic [7:0] s;
      logic       cout;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         sel = 0;
   logic       start_drv = 1'b0;
   logic [7:0] a_drv = '0;
   logic [7:0] b_drv = '0;
   logic       cin_drv = 1'b0;
   logic       sub_drv = 1'b0;

   logic       done_sel, busy_sel, cout_sel, ovf_sel;
   logic [7:0] s_sel;
   logic [7:0] s_prev;

   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8)) if0 ();
   serial_adder_if #(.WIDTH(8)) if1 ();
   serial_adder_if #(.WIDTH(4)) if2 ();

   assign if0.start = start_drv && (sel == 0);
   assign if0.A     = a_drv;
   assign if0.B     = b_drv;
   assign if0.Cin   = cin_drv;
   assign if0.Sub   = sub_drv;
   assign if1.start = start_drv && (sel == 1);
   assign if1.A     = a_drv;
   assign if1.B     = b_drv;
   assign if1.Cin   = cin_drv;
   assign if1.Sub   = sub_drv;
   assign if2.start = start_drv && (sel == 2);
   assign if2.A     = a_drv[3:0];
   assign if2.B     = b_drv[3:0];
   assign if2.Cin   = cin_drv;
   assign if2.Sub   = sub_drv;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_d8x1 (.clk(clk), .rst(rst), .bus_io(if0));
   serial_adder #(.WIDTH(8), .DIGIT(4)) u_d8x4 (.clk(clk), .rst(rst), .bus_io(if1));
   serial_adder #(.WIDTH(4), .DIGIT(2)) u_d4x2 (.clk(clk), .rst(rst), .bus_io(if2));

   always_comb begin
      case (sel)
         0: begin
            done_sel = if0.done; busy_sel = if0.busy; s_sel = if0.S;
            cout_sel = if0.Cout; ovf_sel = if0.Ovf;
         end
         1: begin
            done_sel = if1.done; busy_sel = if1.busy; s_sel = if1.S;
            cout_sel = if1.Cout; ovf_sel = if1.Ovf;
         end
         default: begin
            done_sel = if2.done; busy_sel = if2.busy; s_sel = {4'b0, if2.S};
            cout_sel = if2.Cout; ovf_sel = if2.Ovf;
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
      end
   endtask

   function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic sub);
      exp_t       r;
      logic [7:0] mask, am, bo;
      logic [8:0] full;
      mask   = 8'((1 << w) - 1);
      am     = a & mask;
      bo     = (sub ? ~b : b) & mask;
      full   = {1'b0, am} + {1'b0, bo} + 9'(sub ? !cin : cin);
      r.s    = full[7:0] & mask;
      r.cout = full[w];
      r.ovf  = (am[w-1] == bo[w-1]) && (r.s[w-1] != am[w-1]);
      return r;
   endfunction

   function automatic int width_of(input int s);
      return (s == 2) ? 4 : 8;
   endfunction

   function automatic int ncyc_of(input int s);
      return (s == 0) ? 8 : 2;
   endfunction

   // Scoreboard: every done pulse must match the oldest accepted operation.
   always @(negedge clk) begin
      if (done_sel) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("S", 32'(s_sel), 32'(e.s));
            check("Cout", 32'(cout_sel), 32'(e.cout));
            check("Ovf", 32'(ovf_sel), 32'(e.ovf));
         end
      end
   end

   // Called #1 after an edge with the selected DUT idle or in DONE.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub);
      a_drv = a; b_drv = b; cin_drv = cin; sub_drv = sub;
      start_drv = 1'b1;
      s_prev = s_sel;
      @(posedge clk); #1;
      start_drv = 1'b0;
      exp_q.push_back(model(width_of(sel), a, b, cin, sub));
   endtask

   task automatic finish_op(input int cyc0);
      int cyc;
      cyc = cyc0;
      while (!done_sel && cyc < 64) begin
         check("busy_run", 32'(busy_sel), 32'd1);
         check("s_hold", 32'(s_sel), 32'(s_prev));
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", 32'(cyc), 32'(ncyc_of(sel)));
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub);
      launch(a, b, cin, sub);
      finish_op(0);
   endtask

   task automatic idle_check();
      @(posedge clk); #1;
      check("done_drop", 32'(done_sel), 32'd0);
      check("busy_idle", 32'(busy_sel), 32'd0);
   endtask

   initial begin
      int saw_done;

      #1;
      check("rst_busy", 32'(busy_sel), 32'd0);
      check("rst_done", 32'(done_sel), 32'd0);
      check("rst_S", 32'(s_sel), 32'd0);
      check("rst_Cout", 32'(cout_sel), 32'd0);
      check("rst_Ovf", 32'(ovf_sel), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // WIDTH=8, DIGIT=1
      sel = 0;
      do_op(8'h35, 8'h4A, 1'b1, 1'b0);
      idle_check();

      // Reset during RUN cycle 3 aborts with no done.
      launch(8'h10, 8'h20, 1'b0, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy_sel), 32'd0);
      check("mid_rst_done", 32'(done_sel), 32'd0);
      check("mid_rst_S", 32'(s_sel), 32'd0);
      check("mid_rst_Cout", 32'(cout_sel), 32'd0);
      check("mid_rst_Ovf", 32'(ovf_sel), 32'd0);
      #1;
      rst = 1'b0;
      exp_q.delete();
      saw_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done_sel) saw_done++;
      end
      check("no_done_after_rst", 32'(saw_done), 32'd0);

      do_op(8'h10, 8'h20, 1'b0, 1'b1);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0);   // back-to-back from DONE
      idle_check();

      // Starts during RUN are ignored.
      launch(8'h35, 8'h4A, 1'b1, 1'b0);
      a_drv = 8'hFF; b_drv = 8'hFF; sub_drv = 1'b1; cin_drv = 1'b1;
      start_drv = 1'b1;
      @(posedge clk); #1;
      start_drv = 1'b0;
      @(posedge clk); #1;
      start_drv = 1'b1;
      @(posedge clk); #1;
      start_drv = 1'b0;
      @(posedge clk); #1;
      finish_op(4);
      do_op(8'h7F, 8'h01, 1'b0, 1'b0);
      do_op(8'h80, 8'h01, 1'b0, 1'b1);
      idle_check();

      // WIDTH=8, DIGIT=4
      sel = 1;
      @(posedge clk); #1;
      do_op(8'h35, 8'h4A, 1'b1, 1'b0);
      idle_check();
      do_op(8'h10, 8'h20, 1'b0, 1'b1);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0);
      idle_check();

      // WIDTH=4, DIGIT=2 exhaustive
      sel = 2;
      @(posedge clk); #1;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int m = 0; m < 4; m++) begin
               do_op(8'(a), 8'(b), m[0], m[1]);
            end
         end
      end
      idle_check();
      @(posedge clk); #1;
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder/subtractor, the multi-bit sequential successor to the single-bit `fa` cell. It processes `DIGIT` bits per clock over `WIDTH/DIGIT` cycles and holds a registered carry between digits. It provides a start/busy/done handshake and signed-overflow detection. It is the area-lean arithmetic slice for the tutorial datapaths, where a full-width ripple adder is not wanted.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be ≥ 2.
- `DIGIT`, default 1: bits processed per cycle. Must divide `WIDTH`. `N = WIDTH/DIGIT` is the cycle count.
- `clk`  input  1: the single clock; all state updates on the rising edge.
- `rst`  input  1: reset, asynchronous and active-high.
- `start`  input  1: request a new operation. Sampled only when `busy` = 0.
- `A`  input  WIDTH: operand A. Sampled at the accepting edge only.
- `B`  input  WIDTH: operand B. Sampled at the accepting edge only.
- `Cin`  input  1: carry-in for add; borrow-in for subtract. Sampled at the accepting edge.
- `Sub`  input  1: 0 computes A + B + Cin; 1 computes A − B − Cin. Sampled at the accepting edge.
- `busy`  output  1: an operation is in progress.
- `done`  output  1: single-cycle pulse; result outputs were updated at this edge.
- `S`  output  WIDTH: result.
- `Cout`  output  1: carry-out of the final digit. For subtract, 1 = no borrow.
- `Ovf`  output  1: two's-complement signed overflow of the result.

## Operation
- States: IDLE, RUN, DONE.
  - `busy` = 1 only in RUN.
  - `done` = 1 only in DONE.
- Accept: `start` = 1 in IDLE or DONE → RUN. At that edge:
  - latch `A`;
  - latch `B` (stored inverted when `Sub` = 1);
  - carry register = `Cin ^ Sub`;
  - digit counter = 0.
- RUN, each cycle:
  - add the low `DIGIT` bits of the A and B shift registers plus the carry register, using a ripple chain of `fa`-equivalent cells;
  - shift the digit sum in at the MSB end of an internal sum register;
  - shift A and B right by `DIGIT`;
  - update the carry register;
  - increment the counter.
- At the edge that completes digit N−1 → DONE:
  - `S` ← internal sum register contents, including the final digit;
  - `Cout` ← final carry-out;
  - `Ovf` ← carry into bit WIDTH−1 XOR carry out of bit WIDTH−1, taken from the last digit's chain.
- DONE → RUN if `start` = 1, else → IDLE.
- `S`, `Cout` and `Ovf` change only on entry to DONE. They hold through IDLE and through the following RUN until the next DONE.
- Arithmetic is modulo 2^WIDTH; bits beyond WIDTH are never kept.
  - Required identity for add: {Cout, S} = A + B + Cin.
  - For subtract: {Cout, S} = A + ~B + !Cin, i.e. `Cout` = 0 when a borrow occurs.
- `start` while `busy` = 1 is ignored: no restart and no relatch of operands.
- Input changes after the accepting edge have no effect on the operation in flight.

## Timing
- Reset values (immediate, clock-independent):
  - state = IDLE;
  - `busy` = 0, `done` = 0, `S` = 0, `Cout` = 0, `Ovf` = 0;
  - all internal registers 0.
- Reset asserted mid-RUN aborts the operation: no `done` pulse, and outputs return to 0.
- Latency: `start` accepted at edge t0.
  - `busy` = 1 after edges t0 … t0+N−1.
  - `done` = 1 and new `S`/`Cout`/`Ovf` after edge t0+N.
  - `done` = 0 after edge t0+N+1, unless a back-to-back start was accepted in DONE, in which case `busy` = 1.
- Back-to-back throughput: one result per N+1 cycles.
- `DIGIT` = `WIDTH`: N = 1, i.e. one RUN cycle followed by DONE.
- The combinational path per cycle is one DIGIT-bit ripple chain; no path spans WIDTH bits unless `DIGIT` = `WIDTH`.

## Test plan
- WIDTH=8, DIGIT=1; A=8'h35, B=8'h4A, Cin=1, Sub=0 → after 8 busy cycles, `done` pulse with S=8'h80, Cout=0, Ovf=1.
- WIDTH=8, DIGIT=1; A=8'h10, B=8'h20, Cin=0, Sub=1 → S=8'hF0, Cout=0, Ovf=0. Then A=8'hFF, B=8'h01, Sub=0, Cin=0 → S=8'h00, Cout=1, Ovf=0.
- WIDTH=8, DIGIT=4; repeat both vectors above → identical results with `done` 2 cycles after the accepting edge; `S` is held unchanged during RUN.
- Pulse `start` with new operands at cycles 1 and 3 of a RUN → ignored; the first result completes unchanged. Hold `start` high in DONE → new RUN begins with no IDLE cycle.
- Assert `rst` in RUN cycle 3 → `busy`, `done`, `S`, `Cout`, `Ovf` read 0 before the next clock edge; no `done` follows; a new start afterwards completes correctly.
- WIDTH=4, DIGIT=2, exhaustive over all A, B, Cin and Sub (1024 cases) → every result matches the identities above, and Ovf matches sign(A)==sign(±B) && sign(S)!=sign(A).
